ddr4_phy_iob_vref_seq: RTL and testbench

//  Parametrised read-Vref update sequencer for the DDR4 PHY IOB bank.

---
 rtl/ddr4_phy_iob_vref_seq_if.sv | 14 +
 rtl/ddr4_phy_iob_vref_seq.sv | 132 +++++++++++++
 tb/tb_ddr4_phy_iob_vref_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr4_phy_iob_vref_seq_if.sv
// Update-request channel into the IOB read-Vref sequencer.
// Valid/ready: the source holds valid, mask and vref stable until ready is seen.
interface ddr4_phy_iob_vref_seq_if #(
  parameter int BYTES  = 7,
  parameter int VREF_W = 7
) ();
  logic              req_valid;
  logic              req_ready;
  logic [BYTES-1:0]  req_byte_mask;
  logic [VREF_W-1:0] req_vref;

  modport master (output req_valid, output req_byte_mask, output req_vref, input req_ready);
  modport slave  (input req_valid, input req_byte_mask, input req_vref, output req_ready);
endinterface

// File: rtl/ddr4_phy_iob_vref_seq.sv
// Ramps per-byte IOB read-Vref codes toward a target, one byte at a time, in bounded steps.
// Latency per byte: SCAN + k*(STEP + SETTLE_CYCLES); req_ready is low for the whole request.
module ddr4_phy_iob_vref_seq #(
  parameter int BYTES         = 7,
  parameter int VREF_W        = 7,
  parameter int VREF_INIT     = 32,
  parameter int VREF_MAX      = 127,
  parameter int MAX_STEP      = 4,
  parameter int SETTLE_CYCLES = 64,
  localparam int CB_W         = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ddr4_phy_iob_vref_seq_if.slave    req,
  output logic [BYTES*VREF_W-1:0]   mcal_rd_vref_value,
  output logic                      busy,
  output logic [CB_W-1:0]           cur_byte,
  output logic                      done_pulse
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [VREF_W-1:0]        INIT_C   = VREF_W'(VREF_INIT);
  localparam logic [VREF_W-1:0]        MAX_C    = VREF_W'(VREF_MAX);
  localparam logic signed [VREF_W:0]   STEP_LIM = (VREF_W+1)'(MAX_STEP);
  localparam logic [CNT_W-1:0]         SETTLE_C = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_STEP, S_SETTLE, S_DONE} state_t;

  state_t                        state_q;
  logic [BYTES-1:0][VREF_W-1:0]  code_q;
  logic [BYTES-1:0]              pend_q;
  logic [VREF_W-1:0]             tgt_q;
  logic [CB_W-1:0]               cur_byte_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          ready_q;
  logic                          busy_q;
  logic                          done_q;

  logic [CB_W-1:0]               low_idx_d;
  logic [VREF_W-1:0]             cur_code;
  logic [VREF_W-1:0]             req_tgt;
  logic signed [VREF_W:0]        diff;
  logic signed [VREF_W:0]        mag;
  logic [VREF_W-1:0]             step_amt;
  logic [VREF_W-1:0]             step_code_d;

  always_comb begin
    low_idx_d = '0;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx_d = CB_W'(i);
    end
  end

  // Step is clipped to |d|, so a code can never overshoot the target or wrap.
  always_comb begin
    cur_code    = code_q[cur_byte_q];
    req_tgt     = (req.req_vref > MAX_C) ? MAX_C : req.req_vref;
    diff        = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_code});
    mag         = (diff < 0) ? -diff : diff;
    step_amt    = (mag > STEP_LIM) ? STEP_LIM[VREF_W-1:0] : mag[VREF_W-1:0];
    step_code_d = (diff < 0) ? (cur_code - step_amt) : (cur_code + step_amt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      code_q     <= {BYTES{INIT_C}};
      pend_q     <= '0;
      tgt_q      <= INIT_C;
      cur_byte_q <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req.req_valid) begin
            pend_q  <= req.req_byte_mask;
            tgt_q   <= req_tgt;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (pend_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cur_byte_q <= low_idx_d;
            state_q    <= S_STEP;
          end
        end
        S_STEP: begin
          code_q[cur_byte_q] <= step_code_d;
          cnt_q              <= SETTLE_C;
          state_q            <= S_SETTLE;
        end
        S_SETTLE: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            if (cur_code == tgt_q) begin
              pend_q[cur_byte_q] <= 1'b0;
              state_q            <= S_SCAN;
            end else begin
              state_q <= S_STEP;
            end
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req.req_ready        = ready_q;
  assign mcal_rd_vref_value   = code_q;
  assign busy                 = busy_q;
  assign cur_byte             = cur_byte_q;
  assign done_pulse           = done_q;

endmodule

// File: tb/tb_ddr4_phy_iob_vref_seq.sv
// Bench for the read-Vref sequencer: a request-level model predicts every lane change
// and done strobe with its clock edge; a negedge monitor pops and compares them.
module tb_ddr4_phy_iob_vref_seq;

  localparam int BYTES  = 7;
  localparam int VREF_W = 7;
  localparam int INIT   = 32;
  localparam int VMAX   = 127;
  localparam int MSTEP  = 4;
  localparam int SETTLE = 64;
  localparam int BOUND  = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr4_phy_iob_vref_seq_if #(.BYTES(BYTES), .VREF_W(VREF_W)) req_if ();

  logic [BYTES*VREF_W-1:0] vref_bus;
  logic                    busy;
  logic [2:0]              cur_byte;
  logic                    done_pulse;

  ddr4_phy_iob_vref_seq #(
    .BYTES(BYTES), .VREF_W(VREF_W), .VREF_INIT(INIT), .VREF_MAX(VMAX),
    .MAX_STEP(MSTEP), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req                (req_if.slave),
    .mcal_rd_vref_value (vref_bus),
    .busy               (busy),
    .cur_byte           (cur_byte),
    .done_pulse         (done_pulse)
  );

  typedef struct {int kind; int lane; int val; int t;} ev_t;  // kind 0 = lane change, 1 = done

  ev_t sb[$];
  int  model[BYTES];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  acc_edge = 0;
  int  last_done = 0;
  int  done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lane(input logic [BYTES*VREF_W-1:0] b, input int n);
    return int'(b[n*VREF_W +: VREF_W]);
  endfunction

  // Request-level timing: SCAN per byte, then per step one STEP edge plus SETTLE edges,
  // then a final SCAN; the strobe is visible right after that last SCAN edge.
  task automatic predict(input int a, input int mask, input int vref);
    int t, tgt, d, s;
    t   = a;
    tgt = (vref > VMAX) ? VMAX : vref;
    for (int b = 0; b < BYTES; b++) begin
      if (mask[b]) begin
        t += 1;
        do begin
          d = tgt - model[b];
          s = (d > MSTEP) ? MSTEP : ((d < -MSTEP) ? -MSTEP : d);
          t += 1;
          if (s != 0) begin
            model[b] += s;
            sb.push_back('{kind: 0, lane: b, val: model[b], t: t});
          end
          t += SETTLE;
        end while (model[b] != tgt);
      end
    end
    t += 1;
    sb.push_back('{kind: 1, lane: 0, val: 0, t: t});
    last_done = t;
  endtask

  logic [BYTES*VREF_W-1:0] prev;
  ev_t mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev = vref_bus;
    end else begin
      for (int n = 0; n < BYTES; n++) begin
        if (lane(vref_bus, n) != lane(prev, n)) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL lane_change: lane %0d became %0d at edge %0d, required no change", n, lane(vref_bus, n), cyc);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.kind != 0 || mon_e.lane != n || mon_e.val != lane(vref_bus, n) ||
                mon_e.t != cyc || int'(cur_byte) != n) begin
              errors++;
              $display("FAIL lane_change: got lane %0d=%0d edge %0d cur_byte %0d, required kind %0d lane %0d=%0d edge %0d",
                       n, lane(vref_bus, n), cyc, cur_byte, mon_e.kind, mon_e.lane, mon_e.val, mon_e.t);
            end
          end
        end
      end
      if (done_pulse) begin
        checks++;
        done_seen = cyc;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL done_pulse: strobe at edge %0d, required none", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.kind != 1 || mon_e.t != cyc) begin
            errors++;
            $display("FAIL done_pulse: strobe at edge %0d, required kind %0d at edge %0d", cyc, mon_e.kind, mon_e.t);
          end
        end
      end
      prev = vref_bus;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic send(input int mask, input int vref, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    req_if.req_valid     = 1'b1;
    req_if.req_byte_mask = BYTES'(mask);
    req_if.req_vref      = VREF_W'(vref);
    while (!req_if.req_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", int'(req_if.req_ready), 1);
    if (req_if.req_ready) begin
      acc_edge = cyc + 1;
      predict(acc_edge, mask, vref);
    end
    @(posedge clk);
    #1;
    if (!hold) req_if.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_events", sb.size(), 0);
  endtask

  task automatic check_idle_lanes(input string name);
    for (int n = 0; n < BYTES; n++) check(name, lane(vref_bus, n), model[n]);
  endtask

  int d1;

  initial begin
    req_if.req_valid     = 1'b0;
    req_if.req_byte_mask = '0;
    req_if.req_vref      = '0;
    for (int n = 0; n < BYTES; n++) model[n] = INIT;

    repeat (3) @(negedge clk);
    check_idle_lanes("reset_lane");
    check("reset_ready", int'(req_if.req_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_cur_byte", int'(cur_byte), 0);
    check("reset_done", int'(done_pulse), 0);
    rst_n = 1'b1;

    // Single byte, two steps up.
    send(7'b0000001, 40, 1'b0);
    check("busy_after_accept", int'(busy), 1);
    drain();
    check("done_latency_byte0", done_seen - acc_edge, 132);
    check_idle_lanes("lanes_after_byte0");

    // Two bytes, single step down each.
    send(7'b1000010, 30, 1'b0);
    drain();

    // Full-range ramp up, then down to zero.
    send(7'b0000100, 127, 1'b0);
    drain();
    check("byte2_at_top", lane(vref_bus, 2), 127);
    send(7'b0000100, 0, 1'b0);
    drain();
    check("byte2_at_zero", lane(vref_bus, 2), 0);

    // Empty mask: SCAN then DONE, strobe on the edge after the accept edge.
    send(0, int'($urandom_range(0, 127)), 1'b0);
    drain();
    check("done_latency_empty", done_seen - acc_edge, 1);

    // A second request held valid while busy waits for the sequencer to go idle.
    send(7'b0010000, 45, 1'b1);
    @(negedge clk);
    check("ready_while_busy", int'(req_if.req_ready), 0);
    d1 = last_done;
    send(0, 99, 1'b0);
    check("held_req_accept_edge", acc_edge, d1 + 2);
    drain();

    for (int k = 0; k < 8; k++) begin
      send(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), 1'b0);
      drain();
    end
    check_idle_lanes("lanes_after_random");

    // Reset in the middle of a settle window.
    send(7'b0001000, 100, 1'b0);
    repeat (30) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    sb.delete();
    for (int n = 0; n < BYTES; n++) model[n] = INIT;
    check_idle_lanes("async_reset_lane");
    check("async_reset_ready", int'(req_if.req_ready), 1);
    check("async_reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post_reset_ready", int'(req_if.req_ready), 1);
    check_idle_lanes("post_reset_lane");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
